// File: rtl/spi_fifo_shifter.sv
// Byte-wide SPI master with TX/RX FIFOs, selectable CPOL and bit order.
// RX byte counter limits receive-only bursts.
module spi_fifo_shifter #(
    parameter int DIV_W      = 8,
    parameter int LEN_W      = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DIV_W-1:0]              clk_div,
    input  logic [1:0]                    mode,
    input  logic                          cpol,
    input  logic                          lsb_first,
    input  logic [LEN_W-1:0]              new_rx_length,
    input  logic                          set_rx_length,
    input  logic                          wr_req,
    input  logic [7:0]                    data_in,
    input  logic                          rd_req,
    output logic [7:0]                    data_out,
    output logic                          tx_full,
    output logic                          rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          busy,
    input  logic                          MISO,
    output logic                          MOSI,
    output logic                          SCLK
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
    localparam logic [1:0] M_STOP = 2'd0;
    localparam logic [1:0] M_RX   = 2'd1;
    localparam logic [1:0] M_TX   = 2'd2;
    localparam logic [1:0] M_BOTH = 2'd3;

    typedef enum logic [1:0] {IDLE, SHIFTING, UNLOAD} state_t;

    state_t            state_q, state_d;
    logic [7:0]        txm_q [FIFO_DEPTH];
    logic [7:0]        rxm_q [FIFO_DEPTH];
    logic [AW:0]       tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [7:0]        sr_q;
    logic              sclk_q, cpol_q, lsb_q;
    logic [1:0]        mode_q;
    logic [DIV_W-1:0]  clk_cnt_q;
    logic [2:0]        bit_cnt_q;
    logic [LEN_W-1:0]  rx_len_q;

    logic tx_push, tx_pop, rx_push, rx_pop, tx_empty, rx_room;
    logic start_rx, start_tx, start_both, start;
    logic edge_hit, trail, last_bit;

    assign tx_level = tx_wp_q - tx_rp_q;
    assign rx_level = rx_wp_q - rx_rp_q;
    assign tx_full  = (tx_level == DEPTH);
    assign tx_empty = (tx_level == '0);
    assign rx_empty = (rx_level == '0);
    assign rx_room  = (rx_level < DEPTH);
    assign tx_push  = wr_req && !tx_full;
    assign rx_pop   = rd_req && !rx_empty;
    assign data_out = rxm_q[rx_rp_q[AW-1:0]];

    assign start_rx   = (mode == M_RX) && (rx_len_q != '0) && rx_room;
    assign start_tx   = (mode == M_TX) && !tx_empty;
    assign start_both = (mode == M_BOTH) && !tx_empty && rx_room;
    assign start      = start_rx || start_tx || start_both;

    // a trailing edge is SCLK leaving the active (!cpol) level
    assign edge_hit = (clk_cnt_q == clk_div);
    assign trail    = edge_hit && (sclk_q != cpol_q);
    assign last_bit = trail && (bit_cnt_q == 3'd7);

    assign MOSI = lsb_q ? sr_q[0] : sr_q[7];
    assign SCLK = sclk_q;

    // FIFO storage, written on accepted pushes
    always_ff @(posedge clk) begin
        if (tx_push) txm_q[tx_wp_q[AW-1:0]] <= data_in;
        if (rx_push) rxm_q[rx_wp_q[AW-1:0]] <= sr_q;
    end

    // FIFO pointers; full/empty come from pointer difference
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_wp_q <= '0;
            tx_rp_q <= '0;
            rx_wp_q <= '0;
            rx_rp_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = SHIFTING;
            SHIFTING: if (last_bit)
                          state_d = (mode_q == M_RX || mode_q == M_BOTH)
                                  ? UNLOAD : IDLE;
            UNLOAD:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy    = (state_q != IDLE);
        rx_push = (state_q == UNLOAD);
        tx_pop  = (state_q == IDLE) && (start_tx || start_both);
    end

    // shifter datapath: SCLK divider, bit counter, shift register, RX count
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_q    <= 1'b0;
            sr_q      <= 8'hFF;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            rx_len_q  <= '0;
            mode_q    <= M_STOP;
            cpol_q    <= 1'b0;
            lsb_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    sclk_q    <= cpol;
                    clk_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    if (set_rx_length) rx_len_q <= new_rx_length;
                    if (start) begin
                        mode_q <= mode;
                        cpol_q <= cpol;
                        lsb_q  <= lsb_first;
                        sr_q   <= (mode == M_RX) ? 8'hFF
                                : txm_q[tx_rp_q[AW-1:0]];
                    end
                end
                SHIFTING: begin
                    if (edge_hit) begin
                        sclk_q    <= ~sclk_q;
                        clk_cnt_q <= '0;
                        if (trail) begin
                            sr_q      <= lsb_q ? {MISO, sr_q[7:1]}
                                               : {sr_q[6:0], MISO};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                UNLOAD: begin
                    if (mode_q == M_RX && rx_len_q != '0)
                        rx_len_q <= rx_len_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_fifo_shifter.sv
// Directed bench for spi_fifo_shifter: TX, RX, loopback, FIFO full,
// and mid-byte reset, with hand-computed expectations.
module tb_spi_fifo_shifter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  clk_div = 8'd1;
    logic [1:0]  mode = 2'd0;
    logic        cpol = 1'b0;
    logic        lsb_first = 1'b0;
    logic [12:0] new_rx_length = '0;
    logic        set_rx_length = 1'b0;
    logic        wr_req = 1'b0;
    logic [7:0]  data_in = '0;
    logic        rd_req = 1'b0;
    logic [7:0]  data_out;
    logic        tx_full, rx_empty, busy, mosi, sclk;
    logic [2:0]  tx_level, rx_level;

    logic        loop_en = 1'b0;
    logic        miso_r = 1'b0;
    logic [7:0]  pat = '0;
    logic [15:0] cap = '0;
    int          rise_cnt = 0;
    int          bi;
    int          checks = 0;
    int          errors = 0;
    int          n;

    wire miso = loop_en ? mosi : miso_r;

    always #5 clk = ~clk;

    spi_fifo_shifter dut (
        .clk(clk), .reset_n(reset_n), .clk_div(clk_div), .mode(mode),
        .cpol(cpol), .lsb_first(lsb_first), .new_rx_length(new_rx_length),
        .set_rx_length(set_rx_length), .wr_req(wr_req), .data_in(data_in),
        .rd_req(rd_req), .data_out(data_out), .tx_full(tx_full),
        .rx_empty(rx_empty), .tx_level(tx_level), .rx_level(rx_level),
        .busy(busy), .MISO(miso), .MOSI(mosi), .SCLK(sclk)
    );

    // MSB-first MISO source and MOSI capture at each SCLK rise
    always @(posedge sclk) begin
        bi = 7 - (rise_cnt % 8);
        miso_r = pat[bi[2:0]];
        cap = {cap[14:0], mosi};
        rise_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        wr_req = 1'b1;
        data_in = b;
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    task automatic pop();
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic busy_len(output int len);
        int t = 0;
        while (!busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("busy_rise_timeout", busy, 1);
        len = 0;
        while (busy && len < 500) begin
            @(negedge clk);
            len++;
        end
    endtask

    task automatic wait_quiet(input string tag, input int limit);
        int q = 0;
        int t = 0;
        while (q < 8 && t < limit) begin
            @(negedge clk);
            t++;
            q = busy ? 0 : q + 1;
        end
        check(tag, (q >= 8), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 1);
        check("rst_busy", busy, 0);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_tx_level", tx_level, 0);
        check("rst_tx_full", tx_full, 0);

        push(8'hA5);
        push(8'h3C);
        check("tx_level2", tx_level, 2);
        mode = 2'd2;
        busy_len(n);
        check("tx_byte1_len", n, 32);
        busy_len(n);
        check("tx_byte2_len", n, 32);
        cyc(4);
        check("tx_busy_done", busy, 0);
        check("tx_bits", cap, 16'hA53C);
        check("tx_level0", tx_level, 0);
        check("tx_no_rx", rx_level, 0);
        mode = 2'd0;

        new_rx_length = 13'd6;
        set_rx_length = 1'b1;
        cyc(1);
        set_rx_length = 1'b0;
        check("rx_len_load", dut.rx_len_q, 6);
        pat = 8'h81;
        rise_cnt = 0;
        mode = 2'd1;
        wait_quiet("rx_stall", 2000);
        check("rx_level4", rx_level, 4);
        check("rx_head", data_out, 8'h81);
        check("rx_len2", dut.rx_len_q, 2);
        pat = 8'hB2;
        pop();
        pop();
        wait_quiet("rx_rest", 2000);
        check("rx_len0", dut.rx_len_q, 0);
        check("rx_level4b", rx_level, 4);
        check("rx_d0", data_out, 8'h81); pop();
        check("rx_d1", data_out, 8'h81); pop();
        check("rx_d2", data_out, 8'hB2); pop();
        check("rx_d3", data_out, 8'hB2); pop();
        check("rx_drained", rx_empty, 1);
        mode = 2'd0;

        cpol = 1'b1;
        lsb_first = 1'b1;
        loop_en = 1'b1;
        cyc(2);
        check("both_sclk_idle", sclk, 1);
        push(8'h01);
        push(8'h80);
        mode = 2'd3;
        wait_quiet("both_done", 2000);
        check("both_level", rx_level, 2);
        check("both_d0", data_out, 8'h01); pop();
        check("both_d1", data_out, 8'h80); pop();
        check("both_empty", rx_empty, 1);
        check("both_sclk_end", sclk, 1);
        check("both_tx_level", tx_level, 0);
        check("both_idle_mosi", mosi, 0);
        mode = 2'd0;
        cpol = 1'b0;
        lsb_first = 1'b0;
        loop_en = 1'b0;
        cyc(2);

        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        check("full_flag", tx_full, 1);
        check("full_level", tx_level, 4);
        push(8'h55);
        check("full_ignored", tx_level, 4);
        mode = 2'd2;
        wait_quiet("full_drain", 3000);
        check("full_last_bytes", cap, 16'h3344);
        check("full_drained", tx_level, 0);
        check("full_cleared", tx_full, 0);
        mode = 2'd0;

        new_rx_length = 13'd3;
        set_rx_length = 1'b1;
        cyc(1);
        set_rx_length = 1'b0;
        pat = 8'hC3;
        rise_cnt = 0;
        mode = 2'd1;
        n = 0;
        while (rise_cnt < 4 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached", (rise_cnt >= 4), 1);
        check("mid_busy_before", busy, 1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mode = 2'd0;
        check("mid_busy", busy, 0);
        check("mid_rx_empty", rx_empty, 1);
        check("mid_rx_len", dut.rx_len_q, 0);
        check("mid_sclk", sclk, 0);
        check("mid_mosi", mosi, 1);
        cyc(40);
        check("mid_no_push", rx_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
